// File: rtl/mem_wb_stage_if.sv
// MEM/WB stage bus: MEM-side instruction fields plus memory read data in, writeback port and retire counters out.
// master = upstream driver / observer, slave = the writeback stage itself.
interface mem_wb_stage_if #(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 32
);
  logic                  stall;
  logic                  flush;
  logic                  in_valid;
  logic                  regWrite;
  logic                  memToReg;
  logic [2:0]            loadType;
  logic [1:0]            byteSel;
  logic [REG_ADDR_W-1:0] rdAddr;
  logic [DATA_W-1:0]     aluResOut;
  logic [DATA_W-1:0]     readData;

  logic                  wb_valid;
  logic                  wb_regWrite;
  logic [REG_ADDR_W-1:0] wb_rdAddr;
  logic [DATA_W-1:0]     wb_data;
  logic                  wb_misalign;
  logic [CNT_W-1:0]      retire_cnt;
  logic [CNT_W-1:0]      load_cnt;

  modport master (
    output stall, flush, in_valid, regWrite, memToReg, loadType, byteSel, rdAddr, aluResOut, readData,
    input  wb_valid, wb_regWrite, wb_rdAddr, wb_data, wb_misalign, retire_cnt, load_cnt
  );

  modport slave (
    input  stall, flush, in_valid, regWrite, memToReg, loadType, byteSel, rdAddr, aluResOut, readData,
    output wb_valid, wb_regWrite, wb_rdAddr, wb_data, wb_misalign, retire_cnt, load_cnt
  );
endinterface

// File: rtl/mem_wb_stage.sv
// MEM/WB register + writeback: 1-cycle latch, sub-word load extract/extend, regfile write, retire counting.
// stall holds the slot (no write, no retire); flush squashes the instruction being latched and beats stall.
module mem_wb_stage #(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 32
) (
  input logic           clk,
  input logic           rst,
  mem_wb_stage_if.slave bus
);
  localparam logic [2:0] LT_LH  = 3'b001;
  localparam logic [2:0] LT_LHU = 3'b010;
  localparam logic [2:0] LT_LB  = 3'b011;
  localparam logic [2:0] LT_LBU = 3'b100;

  logic                  v_q;
  logic                  rw_q;
  logic                  m2r_q;
  logic [2:0]            lt_q;
  logic [1:0]            bs_q;
  logic [REG_ADDR_W-1:0] rd_q;
  logic [DATA_W-1:0]     alu_q;
  logic                  ld_fresh;
  logic [DATA_W-1:0]     ld_hold;
  logic [CNT_W-1:0]      retire_q;
  logic [CNT_W-1:0]      load_q;

  logic [DATA_W-1:0]     raw;
  logic [DATA_W-1:0]     ext;
  logic [15:0]           half_v;
  logic [7:0]            byte_v;
  logic                  bad_align;
  logic                  misalign;
  logic                  retire;

  assign retire = v_q & ~bus.stall;

  always_ff @(posedge clk) begin
    if (rst) begin
      v_q      <= 1'b0;
      rw_q     <= 1'b0;
      m2r_q    <= 1'b0;
      lt_q     <= '0;
      bs_q     <= '0;
      rd_q     <= '0;
      alu_q    <= '0;
      ld_fresh <= 1'b0;
      ld_hold  <= '0;
      retire_q <= '0;
      load_q   <= '0;
    end else begin
      if (bus.flush) begin
        v_q <= 1'b0;
      end else if (!bus.stall) begin
        v_q   <= bus.in_valid;
        rw_q  <= bus.regWrite;
        m2r_q <= bus.memToReg;
        lt_q  <= bus.loadType;
        bs_q  <= bus.byteSel;
        rd_q  <= bus.rdAddr;
        alu_q <= bus.aluResOut;
      end
      // Memory data is only live in the first WB cycle; keep a copy for stalls of any length.
      ld_fresh <= ~bus.stall;
      if (ld_fresh) ld_hold <= bus.readData;
      if (retire) begin
        retire_q <= retire_q + CNT_W'(1);
        if (m2r_q) load_q <= load_q + CNT_W'(1);
      end
    end
  end

  always_comb begin
    raw    = ld_fresh ? bus.readData : ld_hold;
    half_v = bs_q[1] ? raw[31:16] : raw[15:0];
    byte_v = raw[7:0];
    case (bs_q)
      2'd1:    byte_v = raw[15:8];
      2'd2:    byte_v = raw[23:16];
      2'd3:    byte_v = raw[31:24];
      default: byte_v = raw[7:0];
    endcase

    ext       = raw;
    bad_align = (bs_q != 2'b00);
    case (lt_q)
      LT_LH:  begin ext = {{(DATA_W-16){half_v[15]}}, half_v}; bad_align = bs_q[0]; end
      LT_LHU: begin ext = {{(DATA_W-16){1'b0}}, half_v};       bad_align = bs_q[0]; end
      LT_LB:  begin ext = {{(DATA_W-8){byte_v[7]}}, byte_v};   bad_align = 1'b0;    end
      LT_LBU: begin ext = {{(DATA_W-8){1'b0}}, byte_v};        bad_align = 1'b0;    end
      default: ;
    endcase
    misalign = v_q & m2r_q & bad_align;
  end

  assign bus.wb_valid    = v_q;
  assign bus.wb_rdAddr   = rd_q;
  assign bus.wb_misalign = misalign;
  assign bus.wb_data     = !v_q ? '0 : (m2r_q ? ext : alu_q);
  assign bus.wb_regWrite = v_q & rw_q & ~misalign & (rd_q != '0) & ~bus.stall;
  assign bus.retire_cnt  = retire_q;
  assign bus.load_cnt    = load_q;
endmodule

// File: tb/tb_mem_wb_stage.sv
// Bench for mem_wb_stage: directed spec cases then randomized traffic against an instruction-level model.
module tb_mem_wb_stage;
  localparam int DW = 32;
  localparam int AW = 5;
  localparam int CW = 32;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mem_wb_stage_if #(.DATA_W(DW), .REG_ADDR_W(AW), .CNT_W(CW)) bus ();
  mem_wb_stage #(.DATA_W(DW), .REG_ADDR_W(AW), .CNT_W(CW)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {
    bit        valid;
    bit        rw;
    bit        m2r;
    bit [2:0]  lt;
    bit [1:0]  sel;
    bit [4:0]  rd;
    bit [31:0] alu;
    bit [31:0] word;
  } slot_t;

  slot_t       slot;
  int unsigned m_retire;
  int unsigned m_loads;
  bit          fresh;
  bit [31:0]   next_word;
  bit          chk_en = 1'b0;
  int          n_tests = 0;
  int          n_fail  = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // Word-level view of a load: pick the addressed half/byte by shifting, then extend.
  function automatic bit [31:0] model_data(input slot_t s);
    bit [31:0] h;
    bit [31:0] b;
    h = (s.word >> (16 * s.sel[1])) & 32'hFFFF;
    b = (s.word >> (8 * s.sel)) & 32'hFF;
    if (!s.valid) return 32'h0;
    if (!s.m2r) return s.alu;
    case (s.lt)
      3'd1:    return h[15] ? (h | 32'hFFFF_0000) : h;
      3'd2:    return h;
      3'd3:    return b[7] ? (b | 32'hFFFF_FF00) : b;
      3'd4:    return b;
      default: return s.word;
    endcase
  endfunction

  function automatic bit model_mis(input slot_t s);
    bit bad;
    if (s.lt == 3'd1 || s.lt == 3'd2)      bad = (s.sel % 2) != 0;
    else if (s.lt == 3'd3 || s.lt == 3'd4) bad = 1'b0;
    else                                   bad = (s.sel != 0);
    return s.valid && s.m2r && bad;
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      check_val("wb_valid", bus.wb_valid, slot.valid);
      if (slot.valid) check_val("wb_rdAddr", bus.wb_rdAddr, slot.rd);
      check_val("wb_data", bus.wb_data, model_data(slot));
      check_val("wb_misalign", bus.wb_misalign, model_mis(slot));
      check_val("wb_regWrite", bus.wb_regWrite,
                slot.valid && slot.rw && !model_mis(slot) && slot.rd != 0 && !bus.stall);
      check_val("retire_cnt", bus.retire_cnt, m_retire);
      check_val("load_cnt", bus.load_cnt, m_loads);
    end
  end

  // Advance one clock: update the model from the inputs seen at the edge, then present
  // the memory word of the newly latched instruction (garbage on any later cycle).
  task automatic tick();
    @(posedge clk);
    if (rst) begin
      slot     = '{default: 0};
      m_retire = 0;
      m_loads  = 0;
      fresh    = 1'b0;
    end else begin
      if (slot.valid && !bus.stall) begin
        m_retire++;
        if (slot.m2r) m_loads++;
      end
      if (bus.flush) slot.valid = 1'b0;
      else if (!bus.stall) begin
        slot.valid = bus.in_valid;
        slot.rw    = bus.regWrite;
        slot.m2r   = bus.memToReg;
        slot.lt    = bus.loadType;
        slot.sel   = bus.byteSel;
        slot.rd    = bus.rdAddr;
        slot.alu   = bus.aluResOut;
        slot.word  = next_word;
      end
      fresh = !bus.stall;
    end
    #1;
    bus.readData = fresh ? slot.word : $urandom;
  endtask

  task automatic set_in(input bit v, input bit rw, input bit m2r, input bit [2:0] lt, input bit [1:0] sel,
                        input bit [4:0] rd, input bit [31:0] alu, input bit [31:0] word,
                        input bit st, input bit fl);
    bus.in_valid  = v;
    bus.regWrite  = rw;
    bus.memToReg  = m2r;
    bus.loadType  = lt;
    bus.byteSel   = sel;
    bus.rdAddr    = rd;
    bus.aluResOut = alu;
    bus.stall     = st;
    bus.flush     = fl;
    next_word     = word;
  endtask

  task automatic idle(input bit st);
    set_in(0, 0, 0, 3'd0, 2'd0, 5'd0, 32'h0, 32'h0, st, 0);
  endtask

  localparam bit [31:0] LDW = 32'h80F0_7F05;
  bit [2:0]  ld_lt  [5] = '{3'd3, 3'd3, 3'd1, 3'd2, 3'd0};
  bit [1:0]  ld_sel [5] = '{2'd1, 2'd2, 2'd2, 2'd2, 2'd0};
  bit [31:0] ld_exp [5] = '{32'h0000_007F, 32'hFFFF_FFF0, 32'hFFFF_80F0, 32'h0000_80F0, 32'h80F0_7F05};

  initial begin
    rst = 1'b1;
    bus.readData = '0;
    idle(0);
    tick();
    chk_en = 1'b1;
    tick();
    rst = 1'b0;
    idle(0);
    #2;
    check_val("rst_valid", bus.wb_valid, 0);
    check_val("rst_we", bus.wb_regWrite, 0);
    check_val("rst_data", bus.wb_data, 0);
    check_val("rst_retire", bus.retire_cnt, 0);
    check_val("rst_loads", bus.load_cnt, 0);
    tick();

    set_in(1, 1, 0, 3'd0, 2'd0, 5'd3, 32'h0000_1234, 32'h0, 0, 0);
    tick();
    idle(0);
    #2;
    check_val("alu_data", bus.wb_data, 32'h0000_1234);
    check_val("alu_we", bus.wb_regWrite, 1);
    tick();
    #2;
    check_val("alu_retire", bus.retire_cnt, 1);

    for (int i = 0; i < 5; i++) begin
      set_in(1, 1, 1, ld_lt[i], ld_sel[i], 5'd5, $urandom, LDW, 0, 0);
      tick();
      idle(0);
      #2;
      check_val("load_data", bus.wb_data, ld_exp[i]);
      tick();
      #2;
      check_val("load_cnt_step", bus.load_cnt, i + 1);
    end

    set_in(1, 1, 1, 3'd0, 2'd0, 5'd7, 32'h0, LDW, 0, 0);
    tick();
    for (int c = 0; c < 3; c++) begin
      idle(1);
      if (c > 0) bus.readData = 32'hDEAD_BEEF;
      #2;
      check_val("stall_data", bus.wb_data, LDW);
      check_val("stall_we", bus.wb_regWrite, 0);
      tick();
      bus.readData = 32'hDEAD_BEEF;
    end
    idle(0);
    #2;
    check_val("release_data", bus.wb_data, LDW);
    check_val("release_we", bus.wb_regWrite, 1);
    tick();
    #2;
    check_val("release_retire", bus.retire_cnt, 7);
    check_val("release_loads", bus.load_cnt, 6);

    set_in(1, 1, 0, 3'd0, 2'd0, 5'd0, 32'h55, 32'h0, 0, 0);
    tick();
    set_in(1, 1, 1, 3'd0, 2'd2, 5'd4, 32'h0, LDW, 0, 0);
    #2;
    check_val("rd0_we", bus.wb_regWrite, 0);
    tick();
    idle(0);
    #2;
    check_val("mis_we", bus.wb_regWrite, 0);
    check_val("mis_flag", bus.wb_misalign, 1);
    tick();
    #2;
    check_val("mis_retire", bus.retire_cnt, 9);
    check_val("mis_loads", bus.load_cnt, 7);

    set_in(1, 1, 0, 3'd0, 2'd0, 5'd2, 32'h77, 32'h0, 0, 0);
    tick();
    set_in(1, 1, 0, 3'd0, 2'd0, 5'd9, 32'h99, 32'h0, 1, 1);
    tick();
    idle(0);
    #2;
    check_val("flush_valid", bus.wb_valid, 0);
    check_val("flush_retire", bus.retire_cnt, 9);

    set_in(1, 1, 1, 3'd0, 2'd0, 5'd6, 32'h0, LDW, 0, 0);
    tick();
    idle(1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    idle(0);
    #2;
    check_val("rst_mid_valid", bus.wb_valid, 0);
    check_val("rst_mid_retire", bus.retire_cnt, 0);

    for (int n = 0; n < 3000; n++) begin
      set_in($urandom_range(0, 3) != 0, $urandom, $urandom, 3'($urandom_range(0, 7)),
             2'($urandom), 5'($urandom), $urandom, $urandom,
             $urandom_range(0, 3) == 0, $urandom_range(0, 9) == 0);
      rst = ($urandom_range(0, 199) == 0);
      tick();
    end
    rst = 1'b0;
    idle(0);
    tick();
    chk_en = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
